// File: rtl/tp_mul_arb_pkg.sv
// Shared definitions for the arbitrated, time-shared signed multiplier.
package tp_mul_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int A_W_DEF  = 16;
    localparam int B_W_DEF  = 16;
    localparam int P_W_DEF  = 30;
    localparam int ID_W     = $clog2(NREQ_DEF);

    // One accepted request as it sits in the first pipeline stage.
    typedef struct packed {
        logic signed [A_W_DEF-1:0] a;
        logic signed [B_W_DEF-1:0] b;
        logic [ID_W-1:0]           id;
    } req_slot_t;

endpackage

// File: rtl/tp_mul_16s_16s_30.sv
// Combinational signed multiplier; the product is truncated to its low P_W bits,
// so out-of-range products wrap (e.g. -32768 * -32768 gives 0).
module tp_mul_16s_16s_30 #(
    parameter int A_W = 16,
    parameter int B_W = 16,
    parameter int P_W = 30
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic signed [P_W-1:0] p_o
);

    logic signed [A_W+B_W-1:0] full_prod;
    logic                      unused_hi;

    assign full_prod = a_i * b_i;
    assign p_o       = full_prod[P_W-1:0];
    assign unused_hi = ^full_prod[A_W+B_W-1:P_W];

endmodule

// File: rtl/tp_mul_share_arb.sv
// Round-robin arbiter feeding one shared signed multiplier through a two-stage
// pipeline (S1: operands, S2: product) with full-throughput backpressure.
//
// Handshake: a requester transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a result transfers where res_valid and res_ready
// are both high. req_ready is combinational from req_valid/res_ready/state and
// is at most one-hot; S2 holds res_* steady while res_valid && !res_ready.
module tp_mul_share_arb
    import tp_mul_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int A_W  = A_W_DEF,
    parameter  int B_W  = B_W_DEF,
    parameter  int P_W  = P_W_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*A_W-1:0]   req_a,
    input  logic [NREQ*B_W-1:0]   req_b,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic signed [P_W-1:0] res_p,
    input  logic                  res_ready
);

    logic                  s1_valid_q;
    logic signed [A_W-1:0] s1_a_q;
    logic signed [B_W-1:0] s1_b_q;
    logic [IDW-1:0]        s1_id_q;
    logic                  s2_valid_q;
    logic [IDW-1:0]        s2_id_q;
    logic signed [P_W-1:0] s2_p_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        rr_ptr_d;

    logic                  s2_adv;
    logic                  s1_load;
    logic                  found;
    logic [IDW-1:0]        gid;
    logic                  accept;
    logic signed [P_W-1:0] mul_p;

    // S2 can take new data when empty (bubble collapse) or being drained;
    // S1 moves into S2 on the same condition, so S1 can reload then too.
    assign s2_adv  = !s2_valid_q || res_ready;
    assign s1_load = !s1_valid_q || s2_adv;

    // Round-robin search starting at rr_ptr_q; first valid requester wins.
    always_comb begin : arb
        int idx;
        idx   = 0;
        found = 1'b0;
        gid   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = IDW'(idx);
            end
        end
    end

    // Grant only while out of reset and S1 has room; pointer moves past the winner.
    always_comb begin
        accept    = found && s1_load && !ap_rst;
        req_ready = accept ? (NREQ'(1) << gid) : '0;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(gid) == NREQ - 1) ? '0 : gid + IDW'(1);
        end
    end

    tp_mul_16s_16s_30 #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (mul_p)
    );

    // Round-robin pointer.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Stage 1: capture the granted requester's operands.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q  <= req_a[int'(gid)*A_W +: A_W];
                s1_b_q  <= req_b[int'(gid)*B_W +: B_W];
                s1_id_q <= gid;
            end
        end
    end

    // Stage 2: register the product; contents frozen while stalled.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_id_q <= s1_id_q;
                s2_p_q  <= mul_p;
            end
        end
    end

    assign res_valid = s2_valid_q;
    assign res_id    = s2_id_q;
    assign res_p     = s2_p_q;

endmodule

// File: tb/tb_tp_mul_share_arb.sv
// Directed and random bench for tp_mul_share_arb with default parameters.
module tb_tp_mul_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int PW   = 30;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [63:0]     req_a;
    logic [63:0]     req_b;
    logic            res_valid;
    logic [IDW-1:0]  res_id;
    logic [PW-1:0]   res_p;
    logic            res_ready;

    int total = 0;
    int bad   = 0;

    logic [IDW+PW-1:0] exp_q[$];
    logic              mon_en     = 1'b0;
    logic              stall_prev = 1'b0;
    logic [IDW+PW:0]   prev_res;
    int                acc_cnt    = 0;

    typedef struct {
        string          name;
        int             id;
        int             a;
        int             b;
        logic [PW-1:0]  exp_p;
    } vec_t;

    vec_t vecs[7];

    tp_mul_share_arb dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .res_ready (res_ready)
    );

    // clock
    always #5 ap_clk = ~ap_clk;

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mul_model(input logic signed [15:0] a, input logic signed [15:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[PW-1:0];
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*16 +: 16] = 16'(a);
        req_b[i*16 +: 16] = 16'(b);
    endtask

    task automatic next_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drain(input string name);
        req_valid = '0;
        res_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (exp_q.size() == 0 && !res_valid) break;
            next_cycle();
        end
        next_cycle();
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard / protocol monitor, sampled on the falling edge
    always @(negedge ap_clk) begin
        if (mon_en) begin
            logic [IDW+PW-1:0] e;
            logic legal;
            legal = $onehot0(req_ready) && ((req_ready & ~req_valid) == 4'd0);
            check("ready_legal", {63'd0, legal}, 64'd1);
            if (stall_prev)
                check("stall_stable", {31'd0, res_valid, res_id, res_p}, {31'd0, prev_res});
            stall_prev = res_valid && !res_ready;
            prev_res   = {res_valid, res_id, res_p};
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {32'd0, res_id, res_p}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", {32'd0, res_id, res_p}, {32'd0, e});
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({IDW'(i), mul_model(req_a[i*16 +: 16], req_b[i*16 +: 16])});
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        int a0;
        vecs[0] = '{"v_3x-5",        0, 3,      -5,     30'(-15)};
        vecs[1] = '{"v_max_x_max",   1, 32767,  32767,  30'h3FFF0001};
        vecs[2] = '{"v_min_x_max",   2, -32768, 32767,  30'h0008000};
        vecs[3] = '{"v_min_x_min",   3, -32768, -32768, 30'h0};
        vecs[4] = '{"v_m1_x_m1",     1, -1,     -1,     30'h1};
        vecs[5] = '{"v_1000_x_m1000",3, 1000,   -1000,  30'(-1000000)};
        vecs[6] = '{"v_m1_x_1",      2, -1,     1,      30'h3FFFFFFF};

        // reset state, with all requesters asking
        ap_rst    = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #12;
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_id",    64'(res_id), 64'd0);
        check("rst_res_p",     64'(res_p), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        next_cycle();
        ap_rst    = 1'b0;
        req_valid = '0;

        // table: one requester at a time, exact 2-cycle latency
        for (int v = 0; v < 7; v++) begin
            req_valid = 4'(1 << vecs[v].id);
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            @(negedge ap_clk);
            check({vecs[v].name, "_ready"}, 64'(req_ready), 64'(1 << vecs[v].id));
            next_cycle();
            req_valid = '0;
            @(negedge ap_clk);
            check({vecs[v].name, "_early"}, {63'd0, res_valid}, 64'd0);
            @(negedge ap_clk);
            check({vecs[v].name, "_valid"}, {63'd0, res_valid}, 64'd1);
            check({vecs[v].name, "_id"}, 64'(res_id), 64'(vecs[v].id));
            check({vecs[v].name, "_p"}, 64'(res_p), 64'(vecs[v].exp_p));
            next_cycle();
        end

        // all four continuously valid: rotation and full throughput
        ap_rst = 1'b1;
        #2;
        ap_rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 100);
        req_valid = 4'hF;
        for (int n = 0; n < 12; n++) begin
            @(negedge ap_clk);
            check("rot_ready", 64'(req_ready), 64'(1 << (n % 4)));
            if (n >= 2) begin
                check("rot_valid", {63'd0, res_valid}, 64'd1);
                check("rot_id", 64'(res_id), 64'((n - 2) % 4));
                check("rot_p", 64'(res_p), 64'(((n - 2) % 4 + 1) * 100));
            end
        end
        next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();

        // backpressure: 5 stalled cycles in the middle of a stream
        exp_q.delete();
        stall_prev = 1'b0;
        mon_en     = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 10 * i - 7, -(i + 3));
        req_valid = 4'hF;
        repeat (6) next_cycle();
        res_ready = 1'b0;
        a0 = acc_cnt;
        repeat (5) next_cycle();
        check("bp_accepts_le2", {63'd0, (acc_cnt - a0) <= 2}, 64'd1);
        res_ready = 1'b1;
        repeat (4) next_cycle();
        drain("bp");

        // reset with operations in flight
        req_valid = 4'hF;
        repeat (3) next_cycle();
        ap_rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_id",    64'(res_id), 64'd0);
        check("mid_rst_p",     64'(res_p), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        next_cycle();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        check("post_rst_valid", {63'd0, res_valid}, 64'd0);
        next_cycle();
        repeat (5) next_cycle();
        drain("rst");

        // random traffic against the scoreboard
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        drain("rand");
        check("rand_some_accepts", {63'd0, acc_cnt > 100}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
